// File: rtl/bf16_product_accumulator_pkg.sv
// Shared constants, special encodings and FSM state type for the bf16 product accumulator.
package bf16_product_accumulator_pkg;

  localparam int unsigned EXP_WIDTH  = 8;
  localparam int unsigned MANT_WIDTH = 7;
  localparam int unsigned BIAS       = 127;

  localparam logic [15:0] QNAN    = 16'h7FC0;
  localparam logic [15:0] POS_INF = 16'h7F80;
  localparam logic [15:0] NEG_INF = 16'hFF80;

  typedef enum logic [1:0] {
    StWait,
    StAlign,
    StNorm,
    StHold
  } acc_state_e;

endpackage

// File: rtl/bf16_trunc_adder_core.sv
// Combinational truncating bf16 adder split into an alignment half and a normalization half;
// the caller registers the aligned operands between the two halves.
module bf16_trunc_adder_core #(
  parameter int unsigned BIT_WIDTH  = 16,
  parameter int unsigned EXP_WIDTH  = 8,
  parameter int unsigned MANT_WIDTH = 7,
  parameter int unsigned GUARD_BITS = 3
) (
  // Alignment half
  input  logic [BIT_WIDTH-1:0]                 i_a,
  input  logic [BIT_WIDTH-1:0]                 i_b,
  output logic                                 o_special,
  output logic [BIT_WIDTH-1:0]                 o_special_val,
  output logic                                 o_sign,
  output logic [EXP_WIDTH-1:0]                 o_exp,
  output logic [MANT_WIDTH+GUARD_BITS:0]       o_big_sig,
  output logic [MANT_WIDTH+GUARD_BITS:0]       o_small_sig,
  output logic                                 o_eff_sub,
  // Normalization half
  input  logic                                 i_special,
  input  logic [BIT_WIDTH-1:0]                 i_special_val,
  input  logic                                 i_sign,
  input  logic [EXP_WIDTH-1:0]                 i_exp,
  input  logic [MANT_WIDTH+GUARD_BITS:0]       i_big_sig,
  input  logic [MANT_WIDTH+GUARD_BITS:0]       i_small_sig,
  input  logic                                 i_eff_sub,
  output logic [BIT_WIDTH-1:0]                 o_sum
);
  import bf16_product_accumulator_pkg::*;

  localparam int unsigned SIG_WIDTH = 1 + MANT_WIDTH + GUARD_BITS;
  localparam int unsigned LZ_WIDTH  = $clog2(SIG_WIDTH);
  localparam logic [EXP_WIDTH-1:0] EXP_MAX = '1;

  logic [EXP_WIDTH-1:0]  w_a_exp, w_b_exp, w_big_exp, w_small_exp, w_diff;
  logic [MANT_WIDTH-1:0] w_a_mant, w_b_mant, w_big_mant, w_small_mant;
  logic                  w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic                  w_a_big, w_big_zero, w_small_zero;
  logic [BIT_WIDTH-2:0]  w_a_key, w_b_key;
  logic [SIG_WIDTH-1:0]  w_small_full;

  assign w_a_exp  = i_a[BIT_WIDTH-2 -: EXP_WIDTH];
  assign w_b_exp  = i_b[BIT_WIDTH-2 -: EXP_WIDTH];
  assign w_a_mant = i_a[MANT_WIDTH-1:0];
  assign w_b_mant = i_b[MANT_WIDTH-1:0];
  assign w_a_zero = (w_a_exp == '0);
  assign w_b_zero = (w_b_exp == '0);
  assign w_a_inf  = (w_a_exp == EXP_MAX) && (w_a_mant == '0);
  assign w_b_inf  = (w_b_exp == EXP_MAX) && (w_b_mant == '0);
  assign w_a_nan  = (w_a_exp == EXP_MAX) && (w_a_mant != '0);
  assign w_b_nan  = (w_b_exp == EXP_MAX) && (w_b_mant != '0);
  // Subnormals flush to zero, so their magnitude key is zero too.
  assign w_a_key  = w_a_zero ? '0 : i_a[BIT_WIDTH-2:0];
  assign w_b_key  = w_b_zero ? '0 : i_b[BIT_WIDTH-2:0];
  assign w_a_big  = (w_a_key >= w_b_key);

  assign w_big_exp    = w_a_big ? w_a_exp : w_b_exp;
  assign w_small_exp  = w_a_big ? w_b_exp : w_a_exp;
  assign w_big_mant   = w_a_big ? w_a_mant : w_b_mant;
  assign w_small_mant = w_a_big ? w_b_mant : w_a_mant;
  assign w_big_zero   = w_a_big ? w_a_zero : w_b_zero;
  assign w_small_zero = w_a_big ? w_b_zero : w_a_zero;
  assign w_diff       = w_big_exp - w_small_exp;
  assign w_small_full = {1'b1, w_small_mant, {GUARD_BITS{1'b0}}};

  always_comb begin
    o_special     = 1'b0;
    o_special_val = '0;
    if (w_a_nan || w_b_nan) begin
      o_special     = 1'b1;
      o_special_val = BIT_WIDTH'(QNAN);
    end else if (w_a_inf && w_b_inf) begin
      o_special     = 1'b1;
      o_special_val = (i_a[BIT_WIDTH-1] == i_b[BIT_WIDTH-1]) ? i_a : BIT_WIDTH'(QNAN);
    end else if (w_a_inf) begin
      o_special     = 1'b1;
      o_special_val = i_a;
    end else if (w_b_inf) begin
      o_special     = 1'b1;
      o_special_val = i_b;
    end
  end

  always_comb begin
    o_sign    = w_a_big ? i_a[BIT_WIDTH-1] : i_b[BIT_WIDTH-1];
    o_exp     = w_big_exp;
    o_eff_sub = i_a[BIT_WIDTH-1] ^ i_b[BIT_WIDTH-1];
    o_big_sig = w_big_zero ? '0 : {1'b1, w_big_mant, {GUARD_BITS{1'b0}}};
    if (w_small_zero || (32'(w_diff) > SIG_WIDTH)) begin
      o_small_sig = '0;
    end else begin
      o_small_sig = w_small_full >> w_diff;
    end
  end

  logic [SIG_WIDTH:0]      w_sum;
  logic [LZ_WIDTH-1:0]     w_msb, w_lz;
  logic [EXP_WIDTH-1:0]    w_exp_inc;
  logic [EXP_WIDTH+1:0]    w_exp_dec;
  logic [MANT_WIDTH-1:0]   w_norm_mant;

  assign w_sum = i_eff_sub ? ({1'b0, i_big_sig} - {1'b0, i_small_sig})
                           : ({1'b0, i_big_sig} + {1'b0, i_small_sig});

  always_comb begin
    w_msb = '0;
    for (int i = 0; i < SIG_WIDTH; i++) begin
      if (w_sum[i]) w_msb = LZ_WIDTH'(i);
    end
  end

  assign w_lz        = LZ_WIDTH'(SIG_WIDTH - 1) - w_msb;
  assign w_exp_inc   = i_exp + EXP_WIDTH'(1);
  assign w_exp_dec   = {2'b00, i_exp} - (EXP_WIDTH + 2)'(w_lz);
  // Drop the hidden bit on the way out; guard bits are simply truncated.
  assign w_norm_mant = MANT_WIDTH'((w_sum[SIG_WIDTH-1:0] << w_lz) >> GUARD_BITS);

  always_comb begin
    o_sum = '0;
    if (i_special) begin
      o_sum = i_special_val;
    end else if (w_sum == '0) begin
      o_sum = '0;
    end else if (w_sum[SIG_WIDTH]) begin
      if (w_exp_inc == EXP_MAX) begin
        o_sum = i_sign ? BIT_WIDTH'(NEG_INF) : BIT_WIDTH'(POS_INF);
      end else begin
        o_sum = {i_sign, w_exp_inc, w_sum[SIG_WIDTH-1 -: MANT_WIDTH]};
      end
    end else if (w_exp_dec[EXP_WIDTH+1] || (w_exp_dec == '0)) begin
      o_sum = '0;
    end else begin
      o_sum = {i_sign, w_exp_dec[EXP_WIDTH-1:0], w_norm_mant};
    end
  end

endmodule

// File: rtl/bf16_product_accumulator.sv
// Accumulates a stream of bf16 products into a truncating bf16 running sum, releasing the sum
// and term count when the term marked last has been added.
module bf16_product_accumulator #(
  parameter int unsigned BIT_WIDTH  = 16,
  parameter int unsigned EXP_WIDTH  = 8,
  parameter int unsigned MANT_WIDTH = 7,
  parameter int unsigned GUARD_BITS = 3,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BIT_WIDTH-1:0] in_product,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [BIT_WIDTH-1:0] out_sum,
  output logic [CNT_WIDTH-1:0] out_count,
  output logic                 out_valid,
  input  logic                 out_ready
);
  import bf16_product_accumulator_pkg::*;

  localparam int unsigned SIG_WIDTH = 1 + MANT_WIDTH + GUARD_BITS;

  acc_state_e             r_state;
  logic [BIT_WIDTH-1:0]   r_prod, r_acc;
  logic                   r_last, r_in_ready, r_out_valid;
  logic [CNT_WIDTH-1:0]   r_count;
  logic                   r_special, r_sign, r_eff_sub;
  logic [BIT_WIDTH-1:0]   r_special_val;
  logic [EXP_WIDTH-1:0]   r_exp;
  logic [SIG_WIDTH-1:0]   r_big_sig, r_small_sig;

  logic                   w_special, w_sign, w_eff_sub;
  logic [BIT_WIDTH-1:0]   w_special_val, w_sum;
  logic [EXP_WIDTH-1:0]   w_exp;
  logic [SIG_WIDTH-1:0]   w_big_sig, w_small_sig;

  bf16_trunc_adder_core #(
    .BIT_WIDTH  (BIT_WIDTH),
    .EXP_WIDTH  (EXP_WIDTH),
    .MANT_WIDTH (MANT_WIDTH),
    .GUARD_BITS (GUARD_BITS)
  ) u_core (
    .i_a           (r_acc),
    .i_b           (r_prod),
    .o_special     (w_special),
    .o_special_val (w_special_val),
    .o_sign        (w_sign),
    .o_exp         (w_exp),
    .o_big_sig     (w_big_sig),
    .o_small_sig   (w_small_sig),
    .o_eff_sub     (w_eff_sub),
    .i_special     (r_special),
    .i_special_val (r_special_val),
    .i_sign        (r_sign),
    .i_exp         (r_exp),
    .i_big_sig     (r_big_sig),
    .i_small_sig   (r_small_sig),
    .i_eff_sub     (r_eff_sub),
    .o_sum         (w_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StWait;
      r_prod        <= '0;
      r_last        <= 1'b0;
      r_acc         <= '0;
      r_count       <= '0;
      r_in_ready    <= 1'b1;
      r_out_valid   <= 1'b0;
      r_special     <= 1'b0;
      r_special_val <= '0;
      r_sign        <= 1'b0;
      r_exp         <= '0;
      r_big_sig     <= '0;
      r_small_sig   <= '0;
      r_eff_sub     <= 1'b0;
    end else begin
      case (r_state)
        StWait: begin
          if (in_valid) begin
            r_prod     <= in_product;
            r_last     <= in_last;
            r_in_ready <= 1'b0;
            r_state    <= StAlign;
          end
        end
        StAlign: begin
          r_special     <= w_special;
          r_special_val <= w_special_val;
          r_sign        <= w_sign;
          r_exp         <= w_exp;
          r_big_sig     <= w_big_sig;
          r_small_sig   <= w_small_sig;
          r_eff_sub     <= w_eff_sub;
          r_state       <= StNorm;
        end
        StNorm: begin
          r_acc   <= w_sum;
          r_count <= r_count + CNT_WIDTH'(1);
          if (r_last) begin
            r_out_valid <= 1'b1;
            r_state     <= StHold;
          end else begin
            r_in_ready <= 1'b1;
            r_state    <= StWait;
          end
        end
        StHold: begin
          if (out_ready) begin
            r_acc       <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= StWait;
          end
        end
        default: r_state <= StWait;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_sum   = r_acc;
  assign out_count = r_count;

endmodule

// File: tb/tb_bf16_product_accumulator.sv
// Scoreboard bench: stimulus pushes expected {count, sum}; a monitor compares on every valid cycle.
module tb_bf16_product_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_product;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [15:0] out_sum;
  logic [15:0] out_count;
  logic        out_valid;
  logic        out_ready;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [15:0] grp[$];
  bit          hold_low = 1'b0;

  bf16_product_accumulator dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_product (in_product),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .out_sum    (out_sum),
    .out_count  (out_count),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: align, add, normalize and truncate with plain integer arithmetic.
  function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
    int ea, eb, ma, mb, ka, kb, ebig, esml, sbig, ssml, d, r, e;
    bit sa, sb, sgn;
    ea = int'(a[14:7]); ma = int'(a[6:0]); sa = a[15];
    eb = int'(b[14:7]); mb = int'(b[6:0]); sb = b[15];
    if ((ea == 255 && ma != 0) || (eb == 255 && mb != 0)) return 16'h7FC0;
    if (ea == 255 && eb == 255) return (sa == sb) ? a : 16'h7FC0;
    if (ea == 255) return a;
    if (eb == 255) return b;
    ka = (ea == 0) ? 0 : int'(a[14:0]);
    kb = (eb == 0) ? 0 : int'(b[14:0]);
    if (ka >= kb) begin
      ebig = ea; esml = eb; sgn = sa;
      sbig = (ea == 0) ? 0 : (128 + ma) * 8;
      ssml = (eb == 0) ? 0 : (128 + mb) * 8;
    end else begin
      ebig = eb; esml = ea; sgn = sb;
      sbig = (eb == 0) ? 0 : (128 + mb) * 8;
      ssml = (ea == 0) ? 0 : (128 + ma) * 8;
    end
    d = ebig - esml;
    ssml = (d > 11) ? 0 : (ssml >> d);
    r = (sa == sb) ? sbig + ssml : sbig - ssml;
    if (r == 0) return 16'h0000;
    e = ebig;
    if (r >= 2048) begin
      r = r / 2;
      e = e + 1;
      if (e >= 255) return {sgn, 8'hFF, 7'h00};
    end
    while (r < 1024) begin
      r = r * 2;
      e = e - 1;
    end
    if (e <= 0) return 16'h0000;
    return {sgn, 8'(e), r[9:3]};
  endfunction

  function automatic logic [15:0] gen_term();
    int k;
    k = $urandom_range(0, 19);
    if (k == 0) begin
      case ($urandom_range(0, 5))
        0: return 16'h0000;
        1: return 16'h8000;
        2: return 16'h7F80;
        3: return 16'hFF80;
        4: return 16'h0001;
        default: return 16'h7F7F;
      endcase
    end else if (k < 3) begin
      return 16'($urandom);
    end
    return {1'($urandom), 8'($urandom_range(120, 134)), 7'($urandom)};
  endfunction

  task automatic send_term(input logic [15:0] p, input bit last);
    bit ok;
    ok = 1'b0;
    in_product = p;
    in_last    = last;
    in_valid   = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Sends grp as one sum; leaves the caller 1ns after the edge that accepted the last term.
  task automatic run_group(input logic [15:0] exp_sum, input bit check_lat);
    exp_q.push_back({16'(grp.size()), exp_sum});
    for (int i = 0; i < grp.size(); i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      send_term(grp[i], i == grp.size() - 1);
    end
    if (check_lat) begin
      chk("lat_e0p1_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      chk("lat_e0p1_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      chk("lat_e0p2_valid", 32'(out_valid), 32'd1);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    out_ready = hold_low ? 1'b0 : ($urandom_range(0, 2) != 0);
  end

  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q[0];
          chk("out_sum", 32'(out_sum), 32'(e[15:0]));
          chk("out_count", 32'(out_count), 32'(e[31:16]));
          chk("in_ready_in_hold", 32'(in_ready), 32'd0);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin : stim
    logic [15:0] acc;
    int          n;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_last    = 1'b0;
    in_product = 16'h0000;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    grp = '{16'h3F80, 16'h4000, 16'h3F00};
    run_group(16'h4060, 1'b1);
    wait_drain();
    grp = '{16'h3F80, 16'hBF80};
    run_group(16'h0000, 1'b0);
    grp = '{16'h7F80, 16'hFF80, 16'h3F80};
    run_group(16'h7FC0, 1'b0);
    grp = '{16'h7F7F, 16'h7F7F};
    run_group(16'h7F80, 1'b0);
    grp = '{16'h4B00, 16'h3F80};
    run_group(16'h4B00, 1'b0);
    grp = '{16'h0001};
    run_group(16'h0000, 1'b0);
    wait_drain();

    // Output held back by the consumer must stay put.
    hold_low = 1'b1;
    @(posedge clk); #1;
    grp = '{16'h4040};
    run_group(16'h4040, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_out_sum", 32'(out_sum), 32'h4040);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    hold_low = 1'b0;
    grp = '{16'h3F80};
    run_group(16'h3F80, 1'b0);
    wait_drain();

    // Reset while a term sits in alignment discards it.
    send_term(16'h4000, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_count", 32'(out_count), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    grp = '{16'h3F80};
    run_group(16'h3F80, 1'b0);
    wait_drain();

    for (int g = 0; g < 60; g++) begin
      n   = $urandom_range(1, 6);
      acc = 16'h0000;
      grp = {};
      for (int t = 0; t < n; t++) begin
        grp.push_back(gen_term());
        acc = ref_add(acc, grp[t]);
      end
      run_group(acc, 1'b0);
    end
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
